operation_unit_scheduler: RTL and testbench

//  Shares one fixed-latency AES pipeline plus its 1024-bit side-data delay line among NUM_REQ requesters.

---
 rtl/operation_unit_scheduler.sv | 137 +++++++++++++
 tb/tb_operation_unit_scheduler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/operation_unit_scheduler.sv
// Round-robin issue scheduler for a shared fixed-latency AES pipe; tracks credits and
// carries {src, tag} tokens so results return aligned with the side-data delay line.
module operation_unit_scheduler #(
   parameter int unsigned AES_LATENCY = 29,
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned OUT_CREDITS = 32,
   parameter int unsigned TAG_W       = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             enable,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ*TAG_W-1:0]         req_tag,
   output logic [NUM_REQ-1:0]               req_ready,
   output logic                             issue_valid,
   output logic [$clog2(NUM_REQ)-1:0]       issue_src,
   output logic                             ret_valid,
   output logic [$clog2(NUM_REQ)-1:0]       ret_src,
   output logic [TAG_W-1:0]                 ret_tag,
   input  logic                             credit_return,
   output logic [$clog2(AES_LATENCY+1)-1:0] in_flight,
   output logic                             busy,
   output logic                             err_credit
);

   localparam int unsigned SRC_W = $clog2(NUM_REQ);
   localparam int unsigned IF_W  = $clog2(AES_LATENCY + 1);
   localparam int unsigned CR_W  = $clog2(OUT_CREDITS + 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t            state, state_nxt;
   logic [SRC_W-1:0]  rr_ptr;
   logic [SRC_W-1:0]  grant_idx;
   logic              grant_found;
   logic [TAG_W-1:0]  grant_tag;
   logic              issue;
   logic [CR_W-1:0]   credits;
   logic              cr_ok;
   logic [IF_W-1:0]   in_flight_nxt;

   logic              tok_v [AES_LATENCY];
   logic [SRC_W-1:0]  tok_s [AES_LATENCY];
   logic [TAG_W-1:0]  tok_t [AES_LATENCY];

   // First valid requester at or above rr_ptr, wrapping.
   always_comb begin
      int cand;
      grant_found = 1'b0;
      grant_idx   = '0;
      grant_tag   = '0;
      cand        = 0;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         cand = int'(rr_ptr) + k;
         if (cand >= int'(NUM_REQ)) cand = cand - int'(NUM_REQ);
         if (!grant_found && req_valid[SRC_W'(cand)]) begin
            grant_found = 1'b1;
            grant_idx   = SRC_W'(cand);
            grant_tag   = req_tag[cand*TAG_W +: TAG_W];
         end
      end
   end

   assign issue       = (state == RUN) && enable && (credits != '0) && grant_found;
   assign req_ready   = issue ? (NUM_REQ'(1) << grant_idx) : '0;
   assign issue_valid = |req_ready;
   assign issue_src   = issue ? grant_idx : '0;
   assign cr_ok       = credit_return && (credits != CR_W'(OUT_CREDITS));

   assign ret_valid = tok_v[AES_LATENCY-1];
   assign ret_src   = tok_s[AES_LATENCY-1];
   assign ret_tag   = tok_t[AES_LATENCY-1];

   // Next-state and in-flight bookkeeping.
   always_comb begin
      state_nxt     = state;
      in_flight_nxt = in_flight;
      case ({issue, ret_valid})
         2'b10:   in_flight_nxt = in_flight + IF_W'(1);
         2'b01:   in_flight_nxt = in_flight - IF_W'(1);
         default: in_flight_nxt = in_flight;
      endcase
      case (state)
         IDLE:    if (enable) state_nxt = RUN;
         RUN:     if (!enable) state_nxt = DRAIN;
         DRAIN: begin
            if (enable) state_nxt = RUN;
            else if (in_flight_nxt == '0) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         credits    <= CR_W'(OUT_CREDITS);
         in_flight  <= '0;
         busy       <= 1'b0;
         err_credit <= 1'b0;
      end else begin
         state     <= state_nxt;
         in_flight <= in_flight_nxt;
         busy      <= (state_nxt != IDLE) || (in_flight_nxt != '0);
         if (issue)
            rr_ptr <= (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
         if (issue && !cr_ok)
            credits <= credits - CR_W'(1);
         else if (!issue && cr_ok)
            credits <= credits + CR_W'(1);
         if (credit_return && !cr_ok)
            err_credit <= 1'b1;
      end
   end

   // Token delay line mirroring the AES pipe; reset drops every pending return.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(AES_LATENCY); i++) begin
            tok_v[i] <= 1'b0;
            tok_s[i] <= '0;
            tok_t[i] <= '0;
         end
      end else begin
         tok_v[0] <= issue;
         tok_s[0] <= issue_src;
         tok_t[0] <= issue ? grant_tag : '0;
         for (int i = 1; i < int'(AES_LATENCY); i++) begin
            tok_v[i] <= tok_v[i-1];
            tok_s[i] <= tok_s[i-1];
            tok_t[i] <= tok_t[i-1];
         end
      end
   end

endmodule

// File: tb/tb_operation_unit_scheduler.sv
// Directed bench for operation_unit_scheduler: arbitration table, latency model,
// credit gating, drain and reset-discard sequences.
module tb_operation_unit_scheduler;

   localparam int L = 29;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_tag = 32'hA3A2A1A0;
   logic [3:0]  req_ready;
   logic        issue_valid;
   logic [1:0]  issue_src;
   logic        ret_valid;
   logic [1:0]  ret_src;
   logic [7:0]  ret_tag;
   logic        credit_return = 1'b0;
   logic [4:0]  in_flight;
   logic        busy;
   logic        err_credit;

   int tests = 0;
   int fails = 0;
   bit mon_en = 1'b0;

   // Expected-issue model fed by the stimulus, delayed L cycles.
   bit        exp_iv = 1'b0;
   bit [1:0]  exp_is = '0;
   bit [7:0]  exp_it = '0;
   bit        mv [L];
   bit [1:0]  ms [L];
   bit [7:0]  mt [L];

   typedef struct {
      logic [3:0] rv;
      logic [3:0] exp_rdy;
   } vec_t;
   vec_t tbl [10];

   always #5 clk = ~clk;

   operation_unit_scheduler #(
      .AES_LATENCY(29), .NUM_REQ(4), .OUT_CREDITS(32), .TAG_W(8)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .req_valid(req_valid), .req_tag(req_tag), .req_ready(req_ready),
      .issue_valid(issue_valid), .issue_src(issue_src),
      .ret_valid(ret_valid), .ret_src(ret_src), .ret_tag(ret_tag),
      .credit_return(credit_return), .in_flight(in_flight),
      .busy(busy), .err_credit(err_credit)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < L; i++) begin
            mv[i] <= 1'b0; ms[i] <= '0; mt[i] <= '0;
         end
      end else begin
         mv[0] <= exp_iv; ms[0] <= exp_is; mt[0] <= exp_it;
         for (int i = 1; i < L; i++) begin
            mv[i] <= mv[i-1]; ms[i] <= ms[i-1]; mt[i] <= mt[i-1];
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         check("ret_valid", 32'(ret_valid), 32'(mv[L-1]));
         if (mv[L-1]) begin
            check("ret_src", 32'(ret_src), 32'(ms[L-1]));
            check("ret_tag", 32'(ret_tag), 32'(mt[L-1]));
         end
      end
   end

   // One cycle: drive, check combinational grant, record expected issue, advance.
   task automatic cyc(input logic en, input logic [3:0] rv, input logic cr, input logic [3:0] erdy);
      enable = en; req_valid = rv; credit_return = cr;
      #2;
      check("req_ready", 32'(req_ready), 32'(erdy));
      check("issue_valid", 32'(issue_valid), 32'(|erdy));
      exp_iv = |erdy; exp_is = '0; exp_it = '0;
      for (int i = 0; i < 4; i++)
         if (erdy[i]) begin
            exp_is = 2'(i);
            exp_it = req_tag[i*8 +: 8];
         end
      if (|erdy) check("issue_src", 32'(issue_src), 32'(exp_is));
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n, input logic en);
      for (int i = 0; i < n; i++) cyc(en, 4'b0000, 1'b0, 4'b0000);
   endtask

   task automatic do_reset();
      enable = 1'b0; req_valid = '0; credit_return = 1'b0;
      exp_iv = 1'b0; exp_is = '0; exp_it = '0;
      rst = 1'b1;
      #2;
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_issue_valid", 32'(issue_valid), 0);
      check("rst_ret_valid", 32'(ret_valid), 0);
      check("rst_in_flight", 32'(in_flight), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_err_credit", 32'(err_credit), 0);
      check("rst_credits", 32'(dut.credits), 32);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      tbl[0] = '{4'b0001, 4'b0001};
      tbl[1] = '{4'b0001, 4'b0001};
      tbl[2] = '{4'b1111, 4'b0010};
      tbl[3] = '{4'b0000, 4'b0000};
      tbl[4] = '{4'b1011, 4'b1000};
      tbl[5] = '{4'b1010, 4'b0010};
      tbl[6] = '{4'b0101, 4'b0100};
      tbl[7] = '{4'b0111, 4'b0001};
      tbl[8] = '{4'b1100, 4'b0100};
      tbl[9] = '{4'b1000, 4'b1000};

      @(posedge clk); #1;
      do_reset();
      mon_en = 1'b1;

      // Arbitration table
      cyc(1'b1, 4'b0000, 1'b0, 4'b0000);
      check("busy_run", 32'(busy), 1);
      for (int i = 0; i < 10; i++) cyc(1'b1, tbl[i].rv, 1'b0, tbl[i].exp_rdy);
      idle(32, 1'b1);

      // Single issue, tag 5A, returns exactly L cycles later
      do_reset();
      req_tag = 32'hA3A2A15A;
      cyc(1'b1, 4'b0000, 1'b0, 4'b0000);
      cyc(1'b1, 4'b0001, 1'b0, 4'b0001);
      check("in_flight_1", 32'(in_flight), 1);
      idle(34, 1'b1);
      check("in_flight_0", 32'(in_flight), 0);
      req_tag = 32'hA3A2A1A0;

      // Eight back-to-back issues, round-robin order
      do_reset();
      cyc(1'b1, 4'b0000, 1'b0, 4'b0000);
      for (int k = 0; k < 8; k++) cyc(1'b1, 4'b1111, 1'b0, 4'(1 << (k % 4)));
      idle(32, 1'b1);

      // Credit exhaustion, single credit return, simultaneous issue+return at credits=1
      do_reset();
      cyc(1'b1, 4'b0000, 1'b0, 4'b0000);
      for (int k = 0; k < 32; k++) cyc(1'b1, 4'b1111, 1'b0, 4'(1 << (k % 4)));
      check("in_flight_max", 32'(in_flight), 29);
      check("credits_zero", 32'(dut.credits), 0);
      for (int k = 0; k < 3; k++) cyc(1'b1, 4'b1111, 1'b0, 4'b0000);
      cyc(1'b1, 4'b1111, 1'b1, 4'b0000);
      cyc(1'b1, 4'b1111, 1'b0, 4'b0001);
      cyc(1'b1, 4'b1111, 1'b0, 4'b0000);
      cyc(1'b1, 4'b0000, 1'b1, 4'b0000);
      check("credits_one", 32'(dut.credits), 1);
      cyc(1'b1, 4'b1111, 1'b1, 4'b0010);
      check("credits_still_one", 32'(dut.credits), 1);
      cyc(1'b1, 4'b1111, 1'b0, 4'b0100);
      cyc(1'b1, 4'b1111, 1'b0, 4'b0000);
      idle(32, 1'b1);

      // Credit return while full sets sticky error
      do_reset();
      cyc(1'b1, 4'b0000, 1'b1, 4'b0000);
      check("err_credit_set", 32'(err_credit), 1);
      check("credits_full", 32'(dut.credits), 32);
      idle(4, 1'b1);
      check("err_credit_sticky", 32'(err_credit), 1);

      // Ten issues then drain to idle
      do_reset();
      cyc(1'b1, 4'b0000, 1'b0, 4'b0000);
      for (int k = 0; k < 10; k++) cyc(1'b1, 4'b1111, 1'b0, 4'(1 << (k % 4)));
      check("in_flight_10", 32'(in_flight), 10);
      for (int k = 10; k < 40; k++) begin
         check("busy_drain", 32'(busy), (k <= 38) ? 1 : 0);
         cyc(1'b0, 4'b1111, 1'b0, 4'b0000);
      end
      check("in_flight_drained", 32'(in_flight), 0);

      // Reset mid-flight discards tokens
      do_reset();
      cyc(1'b1, 4'b0000, 1'b0, 4'b0000);
      for (int k = 0; k < 3; k++) cyc(1'b1, 4'b1111, 1'b0, 4'(1 << k));
      idle(5, 1'b1);
      do_reset();
      idle(40, 1'b0);
      check("post_rst_credits", 32'(dut.credits), 32);
      check("post_rst_in_flight", 32'(in_flight), 0);
      check("post_rst_busy", 32'(busy), 0);

      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
